sel4_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one 4:1 selector between four requesters. It drives the selector's 2-bit `sel` and returns a one-hot grant to each requester. It bounds each tenure to a programmable number of cycles so that no requester starves. It sits directly in front of the 4-input selector datapath, and its `sel` output connects straight to the selector's select input.

---
 rtl/sel4_rr_arbiter_pkg.sv | 20 ++
 rtl/sel4_rr_arbiter_if.sv | 13 +
 rtl/sel4_rr_arbiter_rr_pick4.sv | 29 ++
 rtl/sel4_rr_arbiter.sv | 101 ++++++++++
 tb/tb_sel4_rr_arbiter.sv | 144 ++++++++++++++
 5 files changed

// File: rtl/sel4_rr_arbiter_pkg.sv
// Shared types and constants for the 4-way round-robin selector arbiter.
package sel4_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int HOLD_W = 4;
  localparam int N_REQ  = 4;

  // One-hot grant vector for a 2-bit requester index.
  function automatic logic [N_REQ-1:0] onehot4(input logic [1:0] idx);
    logic [N_REQ-1:0] v;
    v      = 4'b0000;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/sel4_rr_arbiter_if.sv
// Request/grant bundle between the four requesters and the arbiter.
interface sel4_rr_arbiter_if;
  import sel4_arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic [1:0]       sel;
  logic             busy;

  modport master (output req, input gnt, input sel, input busy);
  modport slave  (input req, output gnt, output sel, output busy);

endinterface

// File: rtl/sel4_rr_arbiter_rr_pick4.sv
// Combinational rotating-priority picker: first set request at or after ptr, wrapping.
module rr_pick4
  import sel4_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [1:0]       ptr,
  output logic [1:0]       idx,
  output logic             found
);

  logic [1:0] cand_s;

  // Scan four positions starting at ptr; the earliest hit in scan order wins.
  always_comb begin
    idx    = 2'd0;
    found  = 1'b0;
    cand_s = 2'd0;
    for (int i = 0; i < N_REQ; i++) begin
      cand_s = ptr + 2'(i);
      if (!found && req[cand_s]) begin
        found = 1'b1;
        idx   = cand_s;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/sel4_rr_arbiter.sv
// Round-robin arbiter for a shared 4:1 selector with a bounded tenure per grant.
module sel4_rr_arbiter
  import sel4_arb_pkg::*;
#(
  parameter int HOLD_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  sel4_rr_arbiter_if.slave  bus
);

  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(HOLD_MAX);

  state_t            state_r, state_nxt_s;
  logic [1:0]        ptr_r, ptr_nxt_s;
  logic [HOLD_W-1:0] hold_cnt_r, hold_nxt_s;
  logic [N_REQ-1:0]  gnt_r, gnt_nxt_s;
  logic [1:0]        sel_r, sel_nxt_s;
  logic              busy_r, busy_nxt_s;
  logic [1:0]        pick_idx_s;
  logic              pick_found_s;
  logic              keep_s;

  // In GRANT ptr_r already equals owner+1, so the owner is scanned last.
  rr_pick4 u_pick (
    .req   (bus.req),
    .ptr   (ptr_r),
    .idx   (pick_idx_s),
    .found (pick_found_s)
  );

  // Next-state and next-output logic for the two-state grant FSM.
  always_comb begin
    state_nxt_s = state_r;
    ptr_nxt_s   = ptr_r;
    hold_nxt_s  = hold_cnt_r;
    gnt_nxt_s   = gnt_r;
    sel_nxt_s   = sel_r;
    busy_nxt_s  = busy_r;
    keep_s      = bus.req[sel_r] && (hold_cnt_r < HOLD_LIM);
    case (state_r)
      IDLE: begin
        if (pick_found_s) begin
          state_nxt_s = GRANT;
          gnt_nxt_s   = onehot4(pick_idx_s);
          sel_nxt_s   = pick_idx_s;
          busy_nxt_s  = 1'b1;
          hold_nxt_s  = HOLD_W'(1);
          ptr_nxt_s   = pick_idx_s + 2'd1;
        end else begin
          gnt_nxt_s  = 4'b0000;
          busy_nxt_s = 1'b0;
        end
      end
      GRANT: begin
        if (keep_s) begin
          hold_nxt_s = hold_cnt_r + HOLD_W'(1);
        end else if (pick_found_s) begin
          gnt_nxt_s  = onehot4(pick_idx_s);
          sel_nxt_s  = pick_idx_s;
          busy_nxt_s = 1'b1;
          hold_nxt_s = HOLD_W'(1);
          ptr_nxt_s  = pick_idx_s + 2'd1;
        end else begin
          state_nxt_s = IDLE;
          gnt_nxt_s   = 4'b0000;
          busy_nxt_s  = 1'b0;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        gnt_nxt_s   = 4'b0000;
        busy_nxt_s  = 1'b0;
      end
    endcase
  end

  // State, pointer, counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      ptr_r      <= 2'd0;
      hold_cnt_r <= 4'd0;
      gnt_r      <= 4'b0000;
      sel_r      <= 2'd0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      ptr_r      <= ptr_nxt_s;
      hold_cnt_r <= hold_nxt_s;
      gnt_r      <= gnt_nxt_s;
      sel_r      <= sel_nxt_s;
      busy_r     <= busy_nxt_s;
    end
  end

  assign bus.gnt  = gnt_r;
  assign bus.sel  = sel_r;
  assign bus.busy = busy_r;

endmodule

// File: tb/tb_sel4_rr_arbiter.sv
// Directed bench for sel4_rr_arbiter with HOLD_MAX=4 and hand-computed expectations.
module tb_sel4_rr_arbiter;

  logic clk;
  logic rst;
  int   passed;
  int   total;

  sel4_rr_arbiter_if bus ();

  sel4_rr_arbiter #(.HOLD_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    bus.req = 4'b0000;
    step();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    passed  = 0;
    total   = 0;
    rst     = 1'b1;
    bus.req = 4'b0000;
    #1;
    chk("reset_gnt", 32'(bus.gnt), 32'h0);
    chk("reset_sel", 32'(bus.sel), 32'h0);
    chk("reset_busy", 32'(bus.busy), 32'h0);
    step();
    rst = 1'b0;

    // Single requester: continuous grant while the tenure counter wraps.
    bus.req = 4'b0100;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("single_gnt", 32'(bus.gnt), 32'h4);
      chk("single_sel", 32'(bus.sel), 32'h2);
      chk("single_busy", 32'(bus.busy), 32'h1);
      chk("single_hold", 32'(dut.hold_cnt_r), 32'((k % 4) + 1));
    end
    bus.req = 4'b0000;
    step();
    chk("single_idle_gnt", 32'(bus.gnt), 32'h0);
    chk("single_idle_busy", 32'(bus.busy), 32'h0);
    chk("single_idle_sel", 32'(bus.sel), 32'h2);

    // All requesting: 0,1,2,3,0 for four cycles each.
    do_reset();
    bus.req = 4'b1111;
    for (int k = 0; k < 20; k++) begin
      step();
      chk("all_gnt", 32'(bus.gnt), 32'(1 << ((k / 4) % 4)));
      chk("all_sel", 32'(bus.sel), 32'((k / 4) % 4));
      chk("all_busy", 32'(bus.busy), 32'h1);
      chk("all_onehot", 32'($countones(bus.gnt)), 32'h1);
    end

    // Early release: three cycles for requester 0, then 3 with no bubble.
    do_reset();
    bus.req = 4'b1001;
    step();
    chk("early_gnt1", 32'(bus.gnt), 32'h1);
    step();
    chk("early_gnt2", 32'(bus.gnt), 32'h1);
    step();
    chk("early_gnt3", 32'(bus.gnt), 32'h1);
    bus.req = 4'b1000;
    step();
    chk("early_hand_gnt", 32'(bus.gnt), 32'h8);
    chk("early_hand_sel", 32'(bus.sel), 32'h3);
    chk("early_hand_busy", 32'(bus.busy), 32'h1);

    // Go idle from requester 1, then resume scanning at requester 2.
    do_reset();
    bus.req = 4'b0010;
    step();
    chk("idle_pre_gnt", 32'(bus.gnt), 32'h2);
    bus.req = 4'b0000;
    step();
    chk("idle_gnt", 32'(bus.gnt), 32'h0);
    chk("idle_busy", 32'(bus.busy), 32'h0);
    chk("idle_sel", 32'(bus.sel), 32'h1);
    bus.req = 4'b0011;
    step();
    chk("idle_resume_gnt", 32'(bus.gnt), 32'h1);
    chk("idle_resume_sel", 32'(bus.sel), 32'h0);

    // Asynchronous reset between edges.
    do_reset();
    bus.req = 4'b0010;
    step();
    chk("arst_pre_gnt", 32'(bus.gnt), 32'h2);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_gnt", 32'(bus.gnt), 32'h0);
    chk("arst_sel", 32'(bus.sel), 32'h0);
    chk("arst_busy", 32'(bus.busy), 32'h0);
    bus.req = 4'b1111;
    step();
    rst = 1'b0;
    step();
    chk("arst_after_gnt", 32'(bus.gnt), 32'h1);

    // Simultaneous swap: owner 2 drops as requester 1 raises.
    do_reset();
    bus.req = 4'b0100;
    step();
    chk("swap_pre_gnt", 32'(bus.gnt), 32'h4);
    bus.req = 4'b0010;
    step();
    chk("swap_gnt", 32'(bus.gnt), 32'h2);
    chk("swap_sel", 32'(bus.sel), 32'h1);
    chk("swap_busy", 32'(bus.busy), 32'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
